// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file.
// The default widths match the existing RegBus/RegAddrBus widths.
package regfile_mp_pkg;

    localparam int RegBusW     = 32;
    localparam int RegAddrBusW = 5;

    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;
    localparam logic RstEnable   = 1'b1;

    localparam logic [RegBusW-1:0] ZeroWord = '0;

    typedef enum logic {
        REGF_INIT = 1'b0,
        REGF_RUN  = 1'b1
    } regf_state_e;

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter for one address. It reports whether any enabled port targets
// that address, returns the data of the highest-index such port, and flags collisions.
module regfile_wr_arb
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = RegBusW,
    parameter int ADDR_W = RegAddrBusW,
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0]        addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data,
    output logic                     conflict
);

    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit      = 1'b0;
        data     = '0;
        conflict = 1'b0;
        // Ascending scan: a later match overrides, so the highest-index port wins.
        // Address 0 never matches, which makes it neither writable nor a conflict.
        for (int i = 0; i < NUM_WR; i++) begin
            if (we[i] == WriteEnable && waddr[i*ADDR_W +: ADDR_W] == addr && addr != '0) begin
                conflict = conflict | hit;
                hit      = 1'b1;
                data     = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with priority write arbitration, optional
// same-cycle write-to-read bypass, post-reset clear sweep and write-conflict flag.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W       = RegBusW,
    parameter int ADDR_W       = RegAddrBusW,
    parameter int NUM_RD       = 2,
    parameter int NUM_WR       = 2,
    parameter int BYPASS       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     init_done,
    output logic                     wr_conflict
);

    localparam int Depth = 2**ADDR_W;

    regf_state_e       state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              conflict_q;

    logic [DATA_W-1:0] regs [Depth];

    logic [Depth-1:0]  wr_hit;
    logic [Depth-1:0]  wr_conf;
    logic [DATA_W-1:0] wr_data [Depth];

    logic [NUM_RD-1:0] byp_hit;
    logic [NUM_RD-1:0] byp_conf_unused;
    logic [DATA_W-1:0] byp_data [NUM_RD];

    // One arbiter per register resolves which port (if any) writes it this edge.
    for (genvar a = 0; a < Depth; a++) begin : g_wr_sel
        regfile_wr_arb #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_wr_arb (
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
            .addr     (ADDR_W'(a)),
            .hit      (wr_hit[a]),
            .data     (wr_data[a]),
            .conflict (wr_conf[a])
        );
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_byp
        regfile_wr_arb #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_byp_arb (
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
            .addr     (raddr[j*ADDR_W +: ADDR_W]),
            .hit      (byp_hit[j]),
            .data     (byp_data[j]),
            .conflict (byp_conf_unused[j])
        );
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            REGF_INIT: begin
                if (CLEAR_ON_RST != 0) begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(Depth - 1)) begin
                        state_nxt = REGF_RUN;
                    end
                end else begin
                    state_nxt = REGF_RUN;
                end
            end
            REGF_RUN: state_nxt = REGF_RUN;
            default:  state_nxt = REGF_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state      <= REGF_INIT;
            clr_cnt    <= '0;
            conflict_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            conflict_q <= (state == REGF_RUN) && (|wr_conf);
        end
    end

    // NOTE: the storage array has no reset branch; it is cleared by the sweep instead, keeping it a plain RAM.
    always_ff @(posedge clk) begin
        if (rst != RstEnable) begin
            if (state == REGF_INIT) begin
                if (CLEAR_ON_RST != 0) begin
                    regs[clr_cnt] <= '0;
                end
            end else begin
                for (int a = 0; a < Depth; a++) begin
                    if (wr_hit[a]) begin
                        regs[a] <= wr_data[a];
                    end
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (rst != RstEnable && state == REGF_RUN && re[j] == ReadEnable
                && raddr[j*ADDR_W +: ADDR_W] != '0) begin
                if (BYPASS != 0 && byp_hit[j]) begin
                    rdata[j*DATA_W +: DATA_W] = byp_data[j];
                end else begin
                    rdata[j*DATA_W +: DATA_W] = regs[raddr[j*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    assign init_done   = (state == REGF_RUN);
    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a default instance (bypass, clear sweep) and a
// second instance without bypass or sweep share one stimulus stream.
module tb_regfile_mp;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int NW   = 2;
    localparam int NREG = 32;

    logic clk = 1'b0;
    logic rst;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata_a, rdata_b;
    logic             done_a, done_b, conf_a, conf_b;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk (clk), .rst (rst), .we (we), .waddr (waddr), .wdata (wdata),
        .re (re), .raddr (raddr), .rdata (rdata_a),
        .init_done (done_a), .wr_conflict (conf_a)
    );

    regfile_mp #(.BYPASS(0), .CLEAR_ON_RST(0)) u_dut_nb (
        .clk (clk), .rst (rst), .we (we), .waddr (waddr), .wdata (wdata),
        .re (re), .raddr (raddr), .rdata (rdata_b),
        .init_done (done_b), .wr_conflict (conf_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model, one slot per instance: index 0 = default, 1 = no bypass / no sweep.
    bit          m_clear [2] = '{1'b1, 1'b0};
    bit          m_byp   [2] = '{1'b1, 1'b0};
    logic [31:0] m_regs  [2][NREG];
    bit          m_known [2][NREG];
    bit          m_run   [2];
    int          m_cnt   [2];
    bit          m_conf  [2];

    function automatic logic [AW-1:0] wa(input int i);
        return waddr[i*AW +: AW];
    endfunction
    function automatic logic [DW-1:0] wd(input int i);
        return wdata[i*DW +: DW];
    endfunction
    function automatic logic [AW-1:0] ra(input int j);
        return raddr[j*AW +: AW];
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_run[k]  = 1'b0;
                m_cnt[k]  = 0;
                m_conf[k] = 1'b0;
            end else if (!m_run[k]) begin
                m_conf[k] = 1'b0;
                if (m_clear[k]) begin
                    m_regs[k][m_cnt[k]]  = '0;
                    m_known[k][m_cnt[k]] = 1'b1;
                    if (m_cnt[k] == NREG - 1) m_run[k] = 1'b1;
                    m_cnt[k] = (m_cnt[k] + 1) % NREG;
                end else begin
                    m_run[k] = 1'b1;
                end
            end else begin
                m_conf[k] = 1'b0;
                for (int i = 0; i < NW; i++)
                    for (int p = i + 1; p < NW; p++)
                        if (we[i] && we[p] && wa(i) != 0 && wa(i) == wa(p)) m_conf[k] = 1'b1;
                for (int i = 0; i < NW; i++) begin
                    if (we[i] && wa(i) != 0) begin
                        m_regs[k][wa(i)]  = wd(i);
                        m_known[k][wa(i)] = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(input int k, input int j, output bit known);
        int hi;
        known = 1'b1;
        if (rst || !m_run[k] || !re[j] || ra(j) == 0) return 32'h0;
        if (m_byp[k]) begin
            hi = -1;
            for (int i = 0; i < NW; i++)
                if (we[i] && wa(i) == ra(j)) hi = i;
            if (hi >= 0) return wd(hi);
        end
        known = m_known[k][ra(j)];
        return m_regs[k][ra(j)];
    endfunction

    typedef struct {
        string       tag;
        int          inst;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] observe(input int inst, input int kind, input int port);
        logic [NR*DW-1:0] rd;
        rd = (inst == 0) ? rdata_a : rdata_b;
        case (kind)
            0:       return rd[port*DW +: DW];
            1:       return {31'b0, (inst == 0) ? done_a : done_b};
            default: return {31'b0, (inst == 0) ? conf_a : conf_b};
        endcase
    endfunction

    task automatic push(input string tag, input int inst, input int kind, input int port,
                        input logic [31:0] exp);
        exp_t x;
        x.tag  = tag;
        x.inst = inst;
        x.kind = kind;
        x.port = port;
        x.exp  = exp;
        sb.push_back(x);
    endtask

    // Expectations are queued from the stimulus just driven, then drained once outputs settle.
    task automatic sample(input string ctx);
        bit          kn;
        logic [31:0] e;
        exp_t        x;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < NR; j++) begin
                e = exp_rd(k, j, kn);
                if (kn) push($sformatf("%s_i%0d_rd%0d_a%0d", ctx, k, j, ra(j)), k, 0, j, e);
            end
            push($sformatf("%s_i%0d_done", ctx, k), k, 1, 0, {31'b0, m_run[k]});
            push($sformatf("%s_i%0d_conf", ctx, k), k, 2, 0, {31'b0, m_conf[k]});
        end
        #2;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            check(x.tag, observe(x.inst, x.kind, x.port), x.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_wr(input int p, input bit en, input logic [AW-1:0] a, input logic [31:0] d);
        we[p]             = en;
        waddr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input bit en, input logic [AW-1:0] a);
        re[p]             = en;
        raddr[p*AW +: AW] = a;
    endtask

    task automatic wait_sweep(input string ctx);
        int n;
        n = 0;
        do begin
            tick();
            n++;
            sample(ctx);
        end while (!done_a && n < 100);
        check({ctx, "_edges"}, n, 32);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 1'b0; m_cnt[k] = 0; m_conf[k] = 1'b0;
            for (int r = 0; r < NREG; r++) begin
                m_regs[k][r]  = '0;
                m_known[k][r] = 1'b0;
            end
        end

        // Reset state
        set_rd(0, 1'b1, 5'd7);
        set_rd(1, 1'b1, 5'd3);
        tick(); tick();
        sample("reset");

        rst = 1'b0;
        wait_sweep("sweep1");

        // Preload r7, then sweep with a write held on r7 throughout
        set_wr(0, 1'b1, 5'd7, 32'hDEADBEEF);
        sample("preload_byp");
        tick();
        set_wr(0, 1'b0, 5'd7, 32'h0);
        sample("preload");
        set_wr(0, 1'b1, 5'd7, 32'h00001234);
        rst = 1'b1;
        tick();
        sample("rst_pulse");
        rst = 1'b0;
        wait_sweep("sweep2");
        set_wr(0, 1'b0, 5'd7, 32'h0);
        sample("post_sweep");
        check("r7_cleared", rdata_a[DW-1:0], 32'h0);

        // Register 0 is never written; a collision there is not a conflict
        set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        set_wr(1, 1'b1, 5'd0, 32'hFFFFFFFF);
        set_rd(0, 1'b1, 5'd0);
        set_rd(1, 1'b1, 5'd0);
        sample("zero_w");
        tick();
        set_wr(0, 1'b0, 5'd0, 32'h0);
        set_wr(1, 1'b0, 5'd0, 32'h0);
        sample("zero_r");
        check("zero_no_conf", {31'b0, conf_a}, 32'h0);

        // Write priority and a one-cycle conflict pulse
        set_wr(0, 1'b1, 5'd5, 32'h11111111);
        set_wr(1, 1'b1, 5'd5, 32'h22222222);
        set_rd(0, 1'b1, 5'd5);
        set_rd(1, 1'b1, 5'd5);
        sample("prio_w");
        tick();
        set_wr(0, 1'b0, 5'd5, 32'h0);
        set_wr(1, 1'b0, 5'd5, 32'h0);
        sample("prio_r");
        check("prio_r5", rdata_a[DW-1:0], 32'h22222222);
        tick();
        sample("prio_after");

        // Bypass versus stored-only read
        set_wr(0, 1'b1, 5'd9, 32'h01010101);
        tick();
        set_wr(0, 1'b0, 5'd9, 32'h0);
        set_wr(1, 1'b1, 5'd9, 32'hCAFEF00D);
        set_rd(0, 1'b1, 5'd9);
        set_rd(1, 1'b1, 5'd9);
        sample("bypass_same");
        check("bypass_nb_old", rdata_b[DW-1:0], 32'h01010101);
        tick();
        set_wr(1, 1'b0, 5'd9, 32'h0);
        sample("bypass_next");

        // Read enable gating
        set_rd(1, 1'b0, 5'd9);
        sample("rd_dis");
        set_rd(1, 1'b1, 5'd9);
        sample("rd_en");

        // Reset ten edges into the sweep restarts it
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            sample("midsweep");
        end
        rst = 1'b1;
        tick();
        sample("midsweep_rst");
        rst = 1'b0;
        wait_sweep("sweep3");
        for (int r = 0; r < NREG; r += 2) begin
            set_rd(0, 1'b1, AW'(r));
            set_rd(1, 1'b1, AW'(r + 1));
            sample("all_zero");
        end

        // Random traffic over a small address window to provoke collisions
        for (int c = 0; c < 60; c++) begin
            for (int p = 0; p < NW; p++)
                set_wr(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom());
            for (int p = 0; p < NR; p++)
                set_rd(p, 1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)));
            sample("rand");
            tick();
        end
        we = '0;
        sample("rand_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
